// File: rtl/subbytes_pkg.sv
// subbytes_pkg: shared types and constants for the iterative SubBytes block.
// Holds the FSM state encoding and the forward / inverse AES S-box tables.
// Each table is a packed 2048-bit constant; entry x lives at [2047-8x -: 8].
package subbytes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2047:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Fetch entry idx from a packed 256-entry byte table.
    function automatic logic [7:0] sbox_get(input logic [2047:0] tbl, input logic [7:0] idx);
        return tbl[2047 - 8 * int'(idx) -: 8];
    endfunction

endpackage

// File: rtl/sbox_lane.sv
// sbox_lane: one combinational 8-bit S-box lookup.
// Configuration macro: SUBBYTES_INV_EN. When defined, inv selects the inverse
// table; when undefined the inverse table is not referenced and inv is ignored.
module sbox_lane
    import subbytes_pkg::*;
(
    input  logic [7:0] in_byte,
    input  logic       inv,
    output logic [7:0] out_byte
);

`ifdef SUBBYTES_INV_EN
    // Select forward or inverse substitution for this byte.
    always_comb begin
        out_byte = inv ? sbox_get(SBOX_INV, in_byte) : sbox_get(SBOX_FWD, in_byte);
    end
`else
    // Direction select has no effect when only the forward table is built.
    logic inv_unused;
    assign inv_unused = inv;

    // Forward substitution only.
    always_comb begin
        out_byte = sbox_get(SBOX_FWD, in_byte);
    end
`endif

endmodule

// File: rtl/subbytes_iter.sv
// subbytes_iter: iterative AES (Inv)SubBytes over a 128-bit state.
// LANES bytes are substituted per cycle, so a result takes 16/LANES cycles.
// Valid/ready handshake on both sides; the result is held in a separate
// output register so out_data stays stable across the next operation's RUN.
// Configuration macro: SUBBYTES_INV_EN (adds the inverse S-box, honours inv_i).
module subbytes_iter
    import subbytes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         inv_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    // Reject lane counts that do not divide the 16-byte state evenly.
    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Byte offset of the final group; reaching it ends the RUN phase.
    localparam int LAST_CNT = 16 - LANES;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          inv_q, inv_d;
    logic [127:0]  work_q, work_d;
    logic [127:0]  out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;

    logic [7:0]    lane_in  [LANES];
    logic [7:0]    lane_out [LANES];

    // One lookup lane per byte of the current group; lane gi handles byte cnt+gi.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_in[gi] = work_q[127 - 8 * (int'(cnt_q) + gi) -: 8];

            sbox_lane u_lane (
                .in_byte  (lane_in[gi]),
                .inv      (inv_q),
                .out_byte (lane_out[gi])
            );
        end
    endgenerate

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        work_d  = work_q;
        out_d   = out_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    work_d  = in_data;
                    inv_d   = inv_i;
                    cnt_d   = 4'd0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < LANES; i++) begin
                    work_d[127 - 8 * (int'(cnt_q) + i) -: 8] = lane_out[i];
                end
                cnt_d = cnt_q + 4'(LANES);
                if (cnt_q == 4'(LAST_CNT)) begin
                    cnt_d   = 4'd0;
                    out_d   = work_d;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // FSM state, datapath and output flags; reset drops any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            inv_q       <= 1'b0;
            work_q      <= 128'h0;
            out_q       <= 128'h0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            inv_q       <= inv_d;
            work_q      <= work_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_subbytes_iter.sv
// tb_subbytes_iter: directed, table-driven bench for subbytes_iter.
// Instance 0 uses LANES=4 and carries most sequences; instances 1..4 use
// LANES=1,2,8,16 and are exercised together with the FIPS-197 round-1 vector.
module tb_subbytes_iter;

    localparam int NI = 5;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_data;
    logic         inv_i;
    logic         out_ready;

    logic         in_ready_w  [NI];
    logic         out_valid_w [NI];
    logic         busy_w      [NI];
    logic [127:0] out_data_w  [NI];

    int n_vec;
    int n_mis;

    function automatic int lanes_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 1 : (k == 2) ? 2 : (k == 3) ? 8 : 16;
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int LN = (gi == 0) ? 4 : (gi == 1) ? 1 : (gi == 2) ? 2 : (gi == 3) ? 8 : 16;
        subbytes_iter #(.LANES(LN)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[gi]),
            .in_data   (in_data),
            .inv_i     (inv_i),
            .out_valid (out_valid_w[gi]),
            .out_ready (out_ready),
            .out_data  (out_data_w[gi]),
            .busy      (busy_w[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         inv;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[$];

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Offer one state to instance 0, wait for its result, check it and hand it off.
    task automatic run_vec(input string name, input logic inv, input logic [127:0] d,
                           input logic [127:0] exp);
        int cyc;
        cyc = 0;
        while (!in_ready_w[0] && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        chk({name, " in_ready"}, 128'(in_ready_w[0]), 128'd1);
        in_valid = 1'b1;
        in_data  = d;
        inv_i    = inv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~d;
        inv_i    = ~inv;
        chk({name, " busy"}, 128'(busy_w[0]), 128'd1);
        cyc = 0;
        while (!out_valid_w[0] && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        chk({name, " latency"}, 128'(cyc), 128'd4);
        chk({name, " out_data"}, out_data_w[0], exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, " post out_valid"}, 128'(out_valid_w[0]), 128'd0);
        chk({name, " post held"}, out_data_w[0], exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int lat [NI];
        n_vec     = 0;
        n_mis     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 128'h0;
        inv_i     = 1'b0;
        out_ready = 1'b0;

        vecs.push_back('{inv: 1'b0, din: 128'h0, exp: {16{8'h63}}});
        vecs.push_back('{inv: 1'b0, din: FIPS_IN, exp: FIPS_OUT});
        vecs.push_back('{inv: 1'b0, din: {16{8'hff}}, exp: {16{8'h16}}});
        vecs.push_back('{inv: 1'b0, din: 128'h000102030405060708090a0b0c0d0e0f,
                         exp: 128'h637c777bf26b6fc53001672bfed7ab76});
        vecs.push_back('{inv: 1'b0, din: 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff,
                         exp: 128'h8ca1890dbfe6426841992d0fb054bb16});
`ifdef SUBBYTES_INV_EN
        vecs.push_back('{inv: 1'b1, din: FIPS_OUT, exp: FIPS_IN});
        vecs.push_back('{inv: 1'b1, din: 128'h0, exp: {16{8'h52}}});
`else
        vecs.push_back('{inv: 1'b1, din: 128'h0, exp: {16{8'h63}}});
`endif

        // Reset state.
        #12;
        chk("reset out_valid", 128'(out_valid_w[0]), 128'd0);
        chk("reset out_data", out_data_w[0], 128'h0);
        chk("reset busy", 128'(busy_w[0]), 128'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset in_ready", 128'(in_ready_w[0]), 128'd1);

        // Table-driven vectors on the LANES=4 instance.
        foreach (vecs[i]) begin
            run_vec($sformatf("vec%0d", i), vecs[i].inv, vecs[i].din, vecs[i].exp);
        end

        // Backpressure: result held for 5 cycles while new input is offered.
        in_valid = 1'b1; in_data = FIPS_IN; inv_i = 1'b0;
        @(posedge clk); #1;
        in_data = 128'h0;
        cyc = 0;
        while (!out_valid_w[0] && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        chk("bp latency", 128'(cyc), 128'd4);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold valid c%0d", c), 128'(out_valid_w[0]), 128'd1);
            chk($sformatf("bp hold data c%0d", c), out_data_w[0], FIPS_OUT);
            chk($sformatf("bp in_ready c%0d", c), 128'(in_ready_w[0]), 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release in_ready", 128'(in_ready_w[0]), 128'd1);
        chk("bp release out_valid", 128'(out_valid_w[0]), 128'd0);

        // out_ready already high when DONE is entered.
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = {16{8'hff}}; inv_i = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid_w[0] && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        chk("early latency", 128'(cyc), 128'd4);
        chk("early data", out_data_w[0], {16{8'h16}});
        chk("early in_ready during done", 128'(in_ready_w[0]), 128'd0);
        @(posedge clk); #1;
        chk("early out_valid drop", 128'(out_valid_w[0]), 128'd0);
        chk("early in_ready back", 128'(in_ready_w[0]), 128'd1);
        out_ready = 1'b0;

        // Reset in the second RUN cycle.
        in_valid = 1'b1; in_data = 128'h0; inv_i = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 128'(out_valid_w[0]), 128'd0);
        chk("midrst out_data", out_data_w[0], 128'h0);
        chk("midrst busy", 128'(busy_w[0]), 128'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
        end
        chk("midrst no partial", 128'(out_valid_w[0]), 128'd0);
        run_vec("midrst fresh", 1'b0, {16{8'hff}}, {16{8'h16}});

        // FIPS-197 vector on every lane count at once.
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < NI; k++) lat[k] = -1;
        in_valid = 1'b1; in_data = FIPS_IN; inv_i = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;
        for (int c = 0; c <= 20; c++) begin
            for (int k = 0; k < NI; k++) begin
                if (out_valid_w[k] && lat[k] < 0) lat[k] = c;
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("lanes%0d latency", lanes_of(k)), 128'(lat[k]), 128'(16 / lanes_of(k)));
            chk($sformatf("lanes%0d data", lanes_of(k)), out_data_w[k], FIPS_OUT);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("lanes%0d handoff", lanes_of(k)), 128'(out_valid_w[k]), 128'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/subbytes_iter.md
SUBBYTES_ITER -- requirements
Module: subbytes_iter

Interface
REQ-001 SHALL have parameter LANES, default 4, giving the number of S-box lookups per cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data/inv_i are offered.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a new state.
REQ-006 SHALL have port in_data, input, 128 bits: AES state; byte k = in_data[127-8k -: 8], k=0..15.
REQ-007 SHALL have port inv_i, input, 1 bit: 1 = InvSubBytes, 0 = SubBytes; sampled with in_data.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a completed result.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts out_data.
REQ-010 SHALL have port out_data, output, 128 bits: substituted state, same byte order as in_data.
REQ-011 SHALL have port busy, output, 1 bit: high in RUN or DONE.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE; an input is accepted on a clock edge where in_valid && in_ready.
REQ-014 SHALL, on acceptance, capture in_data into the working register, latch inv_i, clear the byte counter to 0, and go to RUN.
REQ-015 SHALL, in RUN, replace bytes cnt..cnt+LANES-1 of the working register with their (inverse) S-box values each cycle, then advance cnt by LANES.
REQ-016 SHALL go from RUN to DONE on the edge that processes the last group (cnt = 16-LANES); out_valid rises exactly 16/LANES cycles after the acceptance edge.
REQ-017 SHALL hold out_valid=1 and keep out_data stable in DONE until out_ready=1, then return to IDLE on that edge.
REQ-018 SHALL ignore changes on in_data, in_valid and inv_i while in RUN or DONE.
REQ-019 SHALL let out_data keep its last value after the output handshake, until the next result.
REQ-020 SHALL, when out_ready is already high on entry to DONE, complete the handshake in one cycle; in_ready returns to 1 on the following cycle.
REQ-021 SHALL complete with LANES=16 in 1 RUN cycle.
REQ-022 SHALL map every byte independently, with no carries or cross-byte effects.

Reset
REQ-023 SHALL, when rst_n=0, go to IDLE immediately and force cnt=0, out_valid=0, out_data=128'h0 and busy=0; in_ready becomes 1 once rst_n=1.
REQ-024 SHALL discard an operation interrupted by reset and produce no partial out_valid.

Configuration
REQ-025 SHALL, with SUBBYTES_INV_EN defined, include the inverse S-box and honour inv_i.
REQ-026 SHALL, without SUBBYTES_INV_EN, exclude the inverse table, ignore inv_i, and always apply the forward S-box.

Structure
REQ-027 SHALL place the forward S-box constant, the inverse S-box constant and the FSM state enum typedef in package subbytes_pkg.
REQ-028 SHALL instantiate LANES copies of sub-module sbox_lane, an 8-bit combinational lookup with an inv select.
REQ-029 SHALL fail elaboration for a LANES value outside {1,2,4,8,16}.

Verification
REQ-030 SHALL cover, with LANES=4: in_data=128'h0, inv_i=0 -> out_data=128'h6363...63, out_valid 4 cycles after acceptance.
REQ-031 SHALL cover the FIPS-197 round-1 vector: in_data=193de3bea0f4e22b9ac68d2ae9f84808 -> out_data=d42711aee0bf98f1b8b45de51e415230, for every legal LANES value.
REQ-032 SHALL cover, with SUBBYTES_INV_EN: d42711aee0bf98f1b8b45de51e415230 with inv_i=1 -> 193de3bea0f4e22b9ac68d2ae9f84808; without the macro, inv_i=1 on 00..00 -> 63..63.
REQ-033 SHALL cover backpressure: out_ready=0 for 5 cycles -> out_valid and out_data held, in_ready=0 throughout; then out_ready=1 -> IDLE next edge.
REQ-034 SHALL cover reset mid-operation: rst_n=0 at RUN cycle 2 -> out_valid=0, out_data=0 immediately; a fresh ff..ff input then -> 16..16.
REQ-035 SHALL cover input changes during RUN: in_data changed during RUN -> result matches the originally accepted data only.
